sipo_framer: RTL

Parametrised serial-in/parallel-out deserialiser with a per-frame shift direction, a bit counter, a one-word output holding register and a valid/ready output handshake. It is the successor to the fixed 4-bit SIPO. It sits between a serial bit source (a UART-style receiver or a test pattern source) and any word-wide consumer. Each complete WIDTH-bit frame is offered exactly once. A frame that cannot be accepted is dropped and flagged.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_shift_core.sv | 58 +++++
 rtl/sipo_framer.sv | 65 ++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO framer: shift-direction encodings and the
// helper that sizes the bit counter from the frame width.
package sipo_pkg;

  localparam logic SIPO_DIR_RIGHT = 1'b0;
  localparam logic SIPO_DIR_LEFT  = 1'b1;

  // Counter width able to hold 0..width-1, never narrower than one bit.
  function automatic int sipo_cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift engine: shift register, bit counter and per-frame direction
// latch. Flags the edge that completes a frame and presents the full word.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = sipo_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             direction,
  input  logic             din,
  input  logic             din_valid,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done,
  output logic [WIDTH-1:0] frame_word
);

  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;

  logic             w_first;
  logic             w_dir;
  logic             w_last;
  logic [WIDTH-1:0] w_next;

  // The first bit of a frame already shifts with the freshly sampled direction.
  always_comb begin
    w_first = (r_cnt == '0);
    w_dir   = w_first ? direction : r_dir;
    w_last  = din_valid && (r_cnt == CNT_W'(WIDTH - 1));
    if (w_dir == SIPO_DIR_LEFT) begin
      w_next = {r_sreg[WIDTH-2:0], din};
    end else begin
      w_next = {din, r_sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_dir  <= SIPO_DIR_LEFT;
    end else if (din_valid) begin
      r_sreg <= w_next;
      if (w_first) begin
        r_dir <= direction;
      end
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign bit_cnt    = r_cnt;
  assign frame_done = w_last;
  assign frame_word = w_next;

endmodule

// File: rtl/sipo_framer.sv
// Deserialiser top: wraps the shift core with a one-word holding register,
// a valid/ready output handshake and a sticky overrun flag for dropped frames.
module sipo_framer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = sipo_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             direction,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  logic             w_frame_done;
  logic [WIDTH-1:0] w_frame_word;

  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  sipo_shift_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .direction (direction),
    .din       (din),
    .din_valid (din_valid),
    .bit_cnt   (bit_cnt),
    .frame_done(w_frame_done),
    .frame_word(w_frame_word)
  );

  // A completed word may only land when the holding slot is empty or is
  // being consumed on this same edge; otherwise it is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_frame_done) begin
      if (!r_dout_valid || dout_ready) begin
        r_dout       <= w_frame_word;
        r_dout_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_dout_valid && dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;

endmodule
